softmax_seq_ctrl: RTL and testbench

Phase sequencer for the softmax datapath: IFM stream → async FIFO → indexed register bank → max / exp-LUT accumulate / divide.
- Gates FIFO writes and reads and drains the FIFO into the register bank by index.
- Runs three read sweeps over the bank: max-find, exp-sum and normalise.
- Hands each normalised result out with a valid pulse.
- Replaces one-hot register strobes with a binary address plus write enable.

---
 rtl/softmax_seq_ctrl_if.sv | 40 ++++
 rtl/softmax_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_seq_ctrl_if.sv
// Control bundle between the softmax phase sequencer and the FIFO, register bank,
// exp-LUT accumulator and divider it steers.
interface softmax_seq_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              valid_ifm;
    logic              fifo_full;
    logic              fifo_empty;
    logic              div_done;
    logic              wr_ifm;
    logic              rd_ifm;
    logic              wr_clr;
    logic              rd_clr;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] rd_sel;
    logic              max_clr;
    logic              max_en;
    logic              acc_clr;
    logic              acc_en;
    logic              div_start;
    logic              out_valid;
    logic [ADDR_W-1:0] out_idx;
    logic              busy;
    logic              err_ovf;

    modport master (
        input  valid_ifm, fifo_full, fifo_empty, div_done,
        output wr_ifm, rd_ifm, wr_clr, rd_clr, reg_wr_en, reg_addr, rd_sel,
               max_clr, max_en, acc_clr, acc_en, div_start, out_valid, out_idx,
               busy, err_ovf
    );

    modport slave (
        output valid_ifm, fifo_full, fifo_empty, div_done,
        input  wr_ifm, rd_ifm, wr_clr, rd_clr, reg_wr_en, reg_addr, rd_sel,
               max_clr, max_en, acc_clr, acc_en, div_start, out_valid, out_idx,
               busy, err_ovf
    );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Softmax phase sequencer: load the FIFO into the register bank, then sweep the bank
// for max, exp-sum and normalise, handing each divided result out with a valid pulse.
module softmax_seq_ctrl #(
    parameter int IFM_SIZE = 1000,
    parameter int ADDR_W   = 10,
    parameter int LUT_LAT  = 2
) (
    input logic                clk,
    input logic                rst_n,
    softmax_seq_ctrl_if.master bus
);
    localparam int                CW       = ADDR_W + 1;
    localparam int                LW       = $clog2(LUT_LAT + 1);
    localparam logic [CW-1:0]     N        = CW'(IFM_SIZE);
    localparam logic [CW-1:0]     LAST     = CW'(IFM_SIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IFM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAX,
        S_EXP,
        S_NORM_LUT,
        S_NORM_WAIT,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       wcnt, rcnt, scnt, ecnt;
    logic [LW-1:0]       lcnt;
    logic [LUT_LAT-1:0]  lut_pipe;
    logic                reg_wr_en_q;
    logic [ADDR_W-1:0]   reg_addr_q;
    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_idx_q;
    logic                err_q;
    logic                accept, drain, exp_act, sweep, acc_en_c, div_start_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave a latch.
        state_nx    = state;
        // rst_n gates the write strobe so nothing is pushed while reset is held.
        accept      = rst_n && bus.valid_ifm && !bus.fifo_full &&
                      (state == S_IDLE || state == S_LOAD) && (wcnt < N);
        drain       = (state == S_LOAD) && !bus.fifo_empty && (rcnt < N);
        exp_act     = (state == S_EXP) && (scnt < N);
        sweep       = (state == S_MAX) || exp_act ||
                      (state == S_NORM_LUT) || (state == S_NORM_WAIT);
        acc_en_c    = (state == S_EXP) && lut_pipe[LUT_LAT-1];
        div_start_c = (state == S_NORM_LUT) && (lcnt == LW'(LUT_LAT));

        unique case (state)
            S_IDLE:      if (accept) state_nx = S_LOAD;
            S_LOAD:      if (reg_wr_en_q && reg_addr_q == LAST_IDX) state_nx = S_MAX;
            S_MAX:       if (scnt == LAST) state_nx = S_EXP;
            S_EXP:       if (acc_en_c && ecnt == LAST) state_nx = S_NORM_LUT;
            S_NORM_LUT:  if (div_start_c) state_nx = S_NORM_WAIT;
            S_NORM_WAIT: if (bus.div_done) state_nx = (scnt == LAST) ? S_DONE : S_NORM_LUT;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase

        bus.wr_ifm    = accept;
        bus.rd_ifm    = drain;
        bus.wr_clr    = !rst_n || (state == S_DONE);
        bus.rd_clr    = !rst_n || (state == S_DONE);
        bus.reg_wr_en = reg_wr_en_q;
        bus.reg_addr  = reg_addr_q;
        bus.rd_sel    = sweep ? scnt[ADDR_W-1:0] : '0;
        bus.max_clr   = (state == S_MAX) && (scnt == '0);
        bus.max_en    = (state == S_MAX);
        bus.acc_clr   = (state == S_EXP) && (scnt == '0);
        bus.acc_en    = acc_en_c;
        bus.div_start = div_start_c;
        bus.out_valid = out_valid_q;
        bus.out_idx   = out_idx_q;
        bus.busy      = (state != S_IDLE);
        bus.err_ovf   = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            rcnt        <= '0;
            scnt        <= '0;
            ecnt        <= '0;
            lcnt        <= '0;
            lut_pipe    <= '0;
            reg_wr_en_q <= 1'b0;
            reg_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in this block override earlier ones.
            reg_wr_en_q <= drain;
            out_valid_q <= 1'b0;
            // Sweep-active delayed by the LUT latency; the oldest stage is acc_en.
            lut_pipe    <= LUT_LAT'({lut_pipe, exp_act});
            if (drain) begin
                reg_addr_q <= rcnt[ADDR_W-1:0];
                rcnt       <= rcnt + CW'(1);
            end
            if (accept) wcnt <= wcnt + CW'(1);
            if (bus.valid_ifm && !accept) err_q <= 1'b1;

            unique case (state)
                S_MAX: scnt <= (scnt == LAST) ? '0 : scnt + CW'(1);
                S_EXP: begin
                    if (exp_act) scnt <= scnt + CW'(1);
                    if (acc_en_c) begin
                        ecnt <= ecnt + CW'(1);
                        if (ecnt == LAST) begin
                            scnt <= '0;
                            ecnt <= '0;
                        end
                    end
                end
                S_NORM_LUT: lcnt <= div_start_c ? '0 : lcnt + LW'(1);
                S_NORM_WAIT: begin
                    if (bus.div_done) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= scnt[ADDR_W-1:0];
                        scnt        <= scnt + CW'(1);
                    end
                end
                S_DONE: begin
                    wcnt <= '0;
                    rcnt <= '0;
                    scnt <= '0;
                    ecnt <= '0;
                    lcnt <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: a phase-timeline model predicts every output each cycle,
// plus literal pulse counts and latencies for the directed scenarios.
module tb_softmax_seq_ctrl;
    localparam int N      = 4;
    localparam int AW     = 2;
    localparam int L      = 2;
    localparam int D      = 3;
    localparam int P      = L + D + 1;    // cycles per normalised index
    localparam int B      = 2 * N + L;    // NORM start, counted from the first MAX cycle
    localparam int DONE_K = B + N * P;

    localparam int C_WR = 0, C_RWE = 1, C_MAX = 2, C_ACC = 3, C_DS = 4, C_OV = 5, C_CLR = 6;

    typedef enum {P_IDLE, P_LOAD, P_SEQ} phase_t;

    logic clk;
    logic rst_n;
    logic empty_force;
    logic div_spur;
    logic div_model;

    softmax_seq_ctrl_if #(.ADDR_W(AW)) bus ();

    softmax_seq_ctrl #(.IFM_SIZE(N), .ADDR_W(AW), .LUT_LAT(L)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Model state
    phase_t ph = P_IDLE;
    int     k = 0, wcnt_m = 0, rcnt_m = 0, occ = 0, prev_addr = 0, runs_done = 0;
    logic   prev_rd = 1'b0, err_m = 1'b0, in_reset = 1'b1;
    logic   e_wr_s = 1'b0, e_rd_s = 1'b0, e_rwe_s = 1'b0, valid_s = 1'b0;
    int     e_raddr_s = 0;

    int n_checks = 0, n_errors = 0, cyc = 0;
    int cnt [7];
    int base[7];
    int acc_clr_cyc = 0, acc_lat = -1, ds_cyc = 0, ov_lat = -1;
    logic acc_seen = 1'b0;

    assign bus.fifo_empty = (occ == 0) || empty_force;
    assign bus.div_done   = div_model || div_spur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic e_wr, e_rd, e_rwe, e_mclr, e_men, e_aclr, e_aen, e_ds, e_ov, e_clr, e_busy;
        logic sel_chk, raddr_chk;
        int   e_raddr, e_sel, e_oidx, e, j;
        cyc++;
        e_wr = 0; e_rd = 0; e_rwe = 0; e_mclr = 0; e_men = 0; e_aclr = 0; e_aen = 0;
        e_ds = 0; e_ov = 0; e_clr = 0; e_busy = 0; sel_chk = 0; raddr_chk = 0;
        e_raddr = 0; e_sel = 0; e_oidx = 0;
        if (!rst_n) begin
            in_reset = 1; ph = P_IDLE; k = 0; wcnt_m = 0; rcnt_m = 0; occ = 0;
            prev_rd = 0; prev_addr = 0; err_m = 0;
            e_clr = 1; sel_chk = 1; raddr_chk = 1; e_ov = 0;
            check("rst_out_idx", bus.out_idx, 0);
        end else begin
            in_reset = 0;
            if (ph != P_SEQ) begin
                e_wr    = bus.valid_ifm && !bus.fifo_full && (wcnt_m < N);
                e_rd    = (ph == P_LOAD) && !bus.fifo_empty && (rcnt_m < N);
                e_rwe   = prev_rd;
                e_raddr = prev_addr;
                raddr_chk = prev_rd;
                e_busy  = (ph == P_LOAD);
            end else begin
                e_busy = 1;
                if (k < N) begin
                    e_men = 1; e_mclr = (k == 0); e_sel = k; sel_chk = 1;
                end else if (k < B) begin
                    e = k - N;
                    if (e < N) begin e_sel = e; sel_chk = 1; end
                    e_aclr = (e == 0);
                    e_aen  = (e >= L) && (e < N + L);
                end else if (k < DONE_K) begin
                    j = k - B;
                    e_sel = j / P; sel_chk = 1;
                    e_ds  = (j % P == L);
                    e_ov  = (j % P == 0) && (j >= P);
                    e_oidx = j / P - 1;
                end else begin
                    e_clr = 1; e_ov = 1; e_oidx = N - 1;
                end
            end
            cnt[C_WR]  += int'(bus.wr_ifm);
            cnt[C_RWE] += int'(bus.reg_wr_en);
            cnt[C_MAX] += int'(bus.max_en);
            cnt[C_ACC] += int'(bus.acc_en);
            cnt[C_DS]  += int'(bus.div_start);
            cnt[C_OV]  += int'(bus.out_valid);
            cnt[C_CLR] += int'(bus.wr_clr);
            if (bus.acc_clr) begin acc_clr_cyc = cyc; acc_seen = 0; end
            if (bus.acc_en && !acc_seen) begin acc_lat = cyc - acc_clr_cyc; acc_seen = 1; end
            if (bus.div_start) ds_cyc = cyc;
            if (bus.out_valid) ov_lat = cyc - ds_cyc;
        end
        e_wr_s = e_wr; e_rd_s = e_rd; e_rwe_s = e_rwe; e_raddr_s = e_raddr;
        valid_s = bus.valid_ifm;

        check("wr_ifm", bus.wr_ifm, e_wr);
        check("rd_ifm", bus.rd_ifm, e_rd);
        check("wr_clr", bus.wr_clr, e_clr);
        check("rd_clr", bus.rd_clr, e_clr);
        check("reg_wr_en", bus.reg_wr_en, e_rwe);
        if (raddr_chk) check("reg_addr", bus.reg_addr, e_raddr);
        if (sel_chk) check("rd_sel", bus.rd_sel, e_sel);
        check("max_clr", bus.max_clr, e_mclr);
        check("max_en", bus.max_en, e_men);
        check("acc_clr", bus.acc_clr, e_aclr);
        check("acc_en", bus.acc_en, e_aen);
        check("div_start", bus.div_start, e_ds);
        check("out_valid", bus.out_valid, e_ov);
        if (e_ov) check("out_idx", bus.out_idx, e_oidx);
        check("busy", bus.busy, e_busy);
        check("err_ovf", bus.err_ovf, err_m);
    endtask

    task automatic advance();
        if (!in_reset) begin
            if (valid_s && !e_wr_s) err_m = 1;
            if (ph == P_SEQ) begin
                if (k == DONE_K) begin
                    ph = P_IDLE; wcnt_m = 0; rcnt_m = 0; occ = 0; prev_rd = 0;
                    runs_done++;
                end else begin
                    k++;
                end
            end else begin
                occ = occ + int'(e_wr_s) - int'(e_rd_s);
                if (ph == P_LOAD && e_rwe_s && e_raddr_s == N - 1) begin
                    ph = P_SEQ; k = 0;
                end else if (ph == P_IDLE && e_wr_s) begin
                    ph = P_LOAD;
                end
                prev_rd   = e_rd_s;
                prev_addr = rcnt_m;
                rcnt_m   += int'(e_rd_s);
                wcnt_m   += int'(e_wr_s);
            end
        end
        div_model = (ph == P_SEQ) && (k >= B) && (k < DONE_K) && ((k - B) % P == L + D);
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            compare_cycle();
            @(posedge clk);
            #1;
            advance();
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2 rst_n = 0;
        repeat (cycles) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic stream(input int cycles, input logic [31:0] vm, input logic [31:0] fm,
                          input logic [31:0] em);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            bus.valid_ifm = vm[c];
            bus.fifo_full = fm[c];
            empty_force   = em[c];
        end
        @(posedge clk);
        #1;
        bus.valid_ifm = 0;
        bus.fifo_full = 0;
        empty_force   = 0;
    endtask

    task automatic wait_run(input string tag);
        int start;
        start = runs_done;
        for (int b = 0; b < 300 && runs_done == start; b++) @(posedge clk);
        if (runs_done == start) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: run did not complete within 300 cycles", tag);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_model(input int target);
        int b;
        b = 0;
        while (!(ph == P_SEQ && k == target) && b < 300) begin
            @(posedge clk);
            #3;
            b++;
        end
        if (b >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_k%0d_timeout: model step not reached", target);
        end
    endtask

    function automatic int delta(input int i);
        return cnt[i] - base[i];
    endfunction

    initial begin
        rst_n = 0; bus.valid_ifm = 0; bus.fifo_full = 0; empty_force = 0;
        div_spur = 0; div_model = 0;
        for (int i = 0; i < 7; i++) begin cnt[i] = 0; base[i] = 0; end
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #2 rst_n = 1;

        // 1: four back-to-back samples, divider latency 3
        base = cnt;
        stream(4, 32'hF, 32'h0, 32'h0);
        wait_run("t1");
        check("t1_wr_pulses", delta(C_WR), 4);
        check("t1_bank_writes", delta(C_RWE), 4);
        check("t1_max_en", delta(C_MAX), 4);
        check("t1_acc_en", delta(C_ACC), 4);
        check("t1_div_start", delta(C_DS), 4);
        check("t1_out_valid", delta(C_OV), 4);
        check("t1_done_clr", delta(C_CLR), 1);
        check("t1_acc_lat", acc_lat, 2);
        check("t1_ov_lat", ov_lat, 4);
        check("t1_err_ovf", bus.err_ovf, 0);
        check("t1_busy", bus.busy, 0);

        // 2: fifo_full for two cycles mid-stream
        do_reset(2);
        base = cnt;
        stream(6, 32'h3F, 32'h6, 32'h0);
        wait_run("t2");
        check("t2_wr_pulses", delta(C_WR), 4);
        check("t2_out_valid", delta(C_OV), 4);
        check("t2_err_ovf", bus.err_ovf, 1);

        // 3: fifo_empty toggling every other cycle
        do_reset(2);
        base = cnt;
        stream(12, 32'hF, 32'h0, 32'h555);
        wait_run("t3");
        check("t3_bank_writes", delta(C_RWE), 4);
        check("t3_out_valid", delta(C_OV), 4);
        check("t3_err_ovf", bus.err_ovf, 0);

        // 4: fifth sample while still loading
        do_reset(2);
        base = cnt;
        stream(10, 32'h1F, 32'h0, 32'hFF);
        wait_run("t4");
        check("t4_wr_pulses", delta(C_WR), 4);
        check("t4_err_ovf", bus.err_ovf, 1);

        // 5: reset during NORM after out_idx 1, then a fresh vector
        do_reset(2);
        base = cnt;
        stream(4, 32'hF, 32'h0, 32'h0);
        wait_model(B + 2 * P);
        do_reset(2);
        check("t5_partial_out_valid", delta(C_OV), 2);
        check("t5_busy_after_rst", bus.busy, 0);
        base = cnt;
        stream(4, 32'hF, 32'h0, 32'h0);
        wait_run("t5");
        check("t5_out_valid", delta(C_OV), 4);
        check("t5_done_clr", delta(C_CLR), 1);

        // 6: spurious div_done in EXP and before div_start in NORM
        do_reset(2);
        base = cnt;
        stream(4, 32'hF, 32'h0, 32'h0);
        wait_model(N + 1);
        div_spur = 1;
        @(posedge clk);
        #1 div_spur = 0;
        wait_model(B + 1);
        div_spur = 1;
        @(posedge clk);
        #1 div_spur = 0;
        wait_run("t6");
        check("t6_out_valid", delta(C_OV), 4);
        check("t6_div_start", delta(C_DS), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
